// File: rtl/btn_debounce_pkg.sv
// Shared register addresses and per-bit debounce state encoding for the
// push-button slot core.
package btn_debounce_pkg;

    localparam logic [4:0] REG_LEVEL   = 5'd0;
    localparam logic [4:0] REG_PRESS   = 5'd1;
    localparam logic [4:0] REG_RELEASE = 5'd2;
    localparam logic [4:0] REG_RAW     = 5'd3;
    localparam logic [4:0] REG_MASK    = 5'd4;

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_H,
        S_HIGH,
        S_WAIT_L
    } db_state_t;

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: 2-FF synchroniser, stability counter and debounce FSM.
// level/rise/fall/sync are all registered.
module btn_debounce_fsm
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 2_000_000,
    localparam int unsigned CNT_W = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic sync
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             meta;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                S_LOW: begin
                    if (sync) begin
                        state <= S_WAIT_H;
                        cnt   <= '0;
                    end
                end
                S_WAIT_H: begin
                    // Any bounce back to 0 abandons the run; the next 1 restarts at cnt=0.
                    if (!sync) begin
                        state <= S_LOW;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_HIGH;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!sync) begin
                        state <= S_WAIT_L;
                        cnt   <= '0;
                    end
                end
                S_WAIT_L: begin
                    if (sync) begin
                        state <= S_HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_LOW;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_LOW;
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_core.sv
// Push-button MMIO slot core: per-bit debounce, sticky press/release (W1C).
// Optional irq mask register enabled by `define BTN_DEBOUNCE_IRQ_EN.
module btn_debounce_core
    import btn_debounce_pkg::*;
#(
    parameter int unsigned N_BTN     = 3,
    parameter int unsigned DB_CYCLES = 2_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             read,
    input  logic             write,
    input  logic [4:0]       addr,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    input  logic [N_BTN-1:0] din,
    output logic             irq
);

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] sync;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] press_clr;
    logic [N_BTN-1:0] release_clr;
    logic             wr_en;

    // Reads have no side effects, so the read strobe is not needed.
    logic unused_bus;
    assign unused_bus = ^{read, wr_data};

    for (genvar i = 0; i < N_BTN; i++) begin : g_bit
        btn_debounce_fsm #(
            .DB_CYCLES(DB_CYCLES)
        ) u_fsm (
            .clk  (clk),
            .rst  (rst),
            .din  (din[i]),
            .level(level[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .sync (sync[i])
        );
    end

    assign wr_en       = cs && write;
    assign press_clr   = (wr_en && addr == REG_PRESS)   ? wr_data[N_BTN-1:0] : '0;
    assign release_clr = (wr_en && addr == REG_RELEASE) ? wr_data[N_BTN-1:0] : '0;

    // Set is OR-ed after the clear so a same-cycle edge wins over W1C.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press     <= '0;
            release_q <= '0;
        end else begin
            press     <= (press & ~press_clr) | rise;
            release_q <= (release_q & ~release_clr) | fall;
        end
    end

`ifdef BTN_DEBOUNCE_IRQ_EN
    logic [N_BTN-1:0] mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_en && addr == REG_MASK) begin
                mask <= wr_data[N_BTN-1:0];
            end
            irq <= |(press & mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_LEVEL:   rd_data[N_BTN-1:0] = level;
            REG_PRESS:   rd_data[N_BTN-1:0] = press;
            REG_RELEASE: rd_data[N_BTN-1:0] = release_q;
            REG_RAW:     rd_data[N_BTN-1:0] = sync;
`ifdef BTN_DEBOUNCE_IRQ_EN
            REG_MASK:    rd_data[N_BTN-1:0] = mask;
`else
            REG_MASK:    rd_data = '0;
`endif
            default:     rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_btn_debounce_core.sv
// Bench for btn_debounce_core (N_BTN=3, DB_CYCLES=8): directed scenarios plus
// randomized pins/bus against a sample-history reference model.
module tb_btn_debounce_core;

    localparam int unsigned N    = 3;
    localparam int unsigned DB   = 8;
    localparam int          MAXE = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [4:0]    addr = '0;
    logic [31:0]   wr_data = '0;
    logic [31:0]   rd_data;
    logic [N-1:0]  din = '0;
    logic          irq;

    always #5 clk = ~clk;

    btn_debounce_core #(
        .N_BTN    (N),
        .DB_CYCLES(DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .read   (rd),
        .write  (wr),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .din    (din),
        .irq    (irq)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: hist[e] holds the pin value sampled at edge e (0 while in reset).
    // A level flips to v at edge e when the DB+1 samples hist[e-2-DB..e-2] all equal v.
    logic [N-1:0] hist [MAXE];
    int           e;
    logic [N-1:0] m_level, m_press, m_rel, m_rise, m_fall, m_sync, m_mask;
    logic         m_irq;

    task automatic model_reset();
        for (int i = 0; i < MAXE; i++) hist[i] = '0;
        m_level = '0; m_press = '0; m_rel = '0; m_rise = '0; m_fall = '0;
        m_sync = '0; m_mask = '0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] clr_p, clr_r;
        logic         irq_next;
        bit           stable;
        e++;
        if (!rst) begin
            hist[e] = '0;
            m_level = '0; m_press = '0; m_rel = '0; m_rise = '0; m_fall = '0;
            m_sync = '0; m_mask = '0; m_irq = 1'b0;
            return;
        end
        hist[e]  = din;
        clr_p    = (cs && wr && addr == 5'd1) ? wr_data[N-1:0] : '0;
        clr_r    = (cs && wr && addr == 5'd2) ? wr_data[N-1:0] : '0;
        irq_next = |(m_press & m_mask);
        m_press  = (m_press & ~clr_p) | m_rise;
        m_rel    = (m_rel & ~clr_r) | m_fall;
`ifdef BTN_DEBOUNCE_IRQ_EN
        if (cs && wr && addr == 5'd4) m_mask = wr_data[N-1:0];
        m_irq = irq_next;
`else
        m_irq = 1'b0;
`endif
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < int'(N); i++) begin
            stable = 1'b1;
            for (int k = e - 2 - int'(DB); k <= e - 2; k++)
                if (hist[k][i] == m_level[i]) stable = 1'b0;
            if (stable) begin
                m_level[i] = ~m_level[i];
                if (m_level[i]) m_rise[i] = 1'b1;
                else            m_fall[i] = 1'b1;
            end
        end
        m_sync = hist[e-1];
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] r = '0;
        case (a)
            5'd0: r[N-1:0] = m_level;
            5'd1: r[N-1:0] = m_press;
            5'd2: r[N-1:0] = m_rel;
            5'd3: r[N-1:0] = m_sync;
`ifdef BTN_DEBOUNCE_IRQ_EN
            5'd4: r[N-1:0] = m_mask;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check($sformatf("rd_a%0d", addr), rd_data, model_read(addr));
        check("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic set_bus(input logic c, input logic w, input logic [4:0] a, input logic [31:0] d);
        cs = c; wr = w; addr = a; wr_data = d;
    endtask

    task automatic idle();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    initial begin
        int idx;
        model_reset();
        e = int'(DB) + 4;
        #1 rst = 1'b0;
        repeat (3) tick();
        rd_chk(5'd0, 32'h0, "rst_rd0");
        rd_chk(5'd1, 32'h0, "rst_rd1");
        rd_chk(5'd2, 32'h0, "rst_rd2");
        rd_chk(5'd3, 32'h0, "rst_rd3");
        rd_chk(5'd4, 32'h0, "rst_rd4");
        rd_chk(5'd7, 32'h0, "rst_rd7");
        check("rst_irq", {31'd0, irq}, 32'h0);
        rst = 1'b1;
        repeat (2) tick();

        // Clean press of btn0: level visible 10 edges after the first sampling edge.
        din = 3'b001;
        repeat (10) tick();
        rd_chk(5'd0, 32'h0, "lvl_early");
        tick();
        rd_chk(5'd0, 32'h1, "lvl_k10");
        tick();
        rd_chk(5'd1, 32'h1, "press0");
        rd_chk(5'd2, 32'h0, "rel0");

        set_bus(1, 1, 5'd1, 32'h1); tick(); idle();
        rd_chk(5'd1, 32'h0, "w1c_press");

        // Bouncing btn1 with 3-cycle pulses, then held.
        for (int b = 0; b < 2; b++) begin
            din = 3'b011; repeat (3) tick();
            din = 3'b001; repeat (3) tick();
        end
        din = 3'b011;
        repeat (10) tick();
        rd_chk(5'd0, 32'h1, "bounce_hold");
        tick();
        rd_chk(5'd0, 32'h3, "bounce_lvl");
        tick();
        rd_chk(5'd1, 32'h2, "bounce_press");

        // Release btn0, W1C release and press.
        din = 3'b010;
        repeat (12) tick();
        rd_chk(5'd2, 32'h1, "rel_set");
        rd_chk(5'd0, 32'h2, "rel_lvl");
        set_bus(1, 1, 5'd2, 32'h1); tick(); idle();
        rd_chk(5'd2, 32'h0, "w1c_rel");
        set_bus(1, 1, 5'd1, 32'h2); tick(); idle();
        rd_chk(5'd1, 32'h0, "w1c_press2");

        // Set-vs-clear collision on press.
        din = 3'b011;
        repeat (12) tick();
        rd_chk(5'd1, 32'h1, "press_pre");
        din = 3'b111;
        repeat (11) tick();
        set_bus(1, 1, 5'd1, 32'h1); tick(); idle();
        rd_chk(5'd1, 32'h4, "collide");

        // Write without cs and read strobe alone leave state unchanged.
        set_bus(0, 1, 5'd1, 32'h7); tick(); idle();
        rd_chk(5'd1, 32'h4, "nocs_write");
        rd = 1'b1; cs = 1'b1; tick(); rd = 1'b0; cs = 1'b0;
        rd_chk(5'd1, 32'h4, "read_only");

`ifdef BTN_DEBOUNCE_IRQ_EN
        din = 3'b000;
        repeat (12) tick();
        set_bus(1, 1, 5'd1, 32'h7); tick();
        set_bus(1, 1, 5'd2, 32'h7); tick();
        set_bus(1, 1, 5'd4, 32'h2); tick(); idle();
        rd_chk(5'd4, 32'h2, "mask_rd");
        din = 3'b001;
        repeat (13) tick();
        check("irq_masked", {31'd0, irq}, 32'h0);
        din = 3'b011;
        repeat (12) tick();
        check("irq_pre", {31'd0, irq}, 32'h0);
        tick();
        check("irq_on", {31'd0, irq}, 32'h1);
        set_bus(1, 1, 5'd1, 32'h2); tick(); idle();
        tick();
        check("irq_off", {31'd0, irq}, 32'h0);
`else
        set_bus(1, 1, 5'd4, 32'h7); tick(); idle();
        rd_chk(5'd4, 32'h0, "mask_absent");
        check("irq_tied", {31'd0, irq}, 32'h0);
`endif

        // Reset while btn0 is mid-debounce (WAIT_H, cnt=5).
        din = 3'b000;
        repeat (12) tick();
        set_bus(1, 1, 5'd1, 32'h7); tick();
        set_bus(1, 1, 5'd2, 32'h7); tick(); idle();
        din = 3'b001;
        repeat (8) tick();
        rst = 1'b0;
        model_reset();
        #1;
        rd_chk(5'd0, 32'h0, "rst_mid_lvl");
        rd_chk(5'd1, 32'h0, "rst_mid_press");
        repeat (2) tick();
        rst = 1'b1;
        repeat (10) tick();
        rd_chk(5'd0, 32'h0, "post_rst_early");
        tick();
        rd_chk(5'd0, 32'h1, "post_rst_lvl");
        rd_chk(5'd1, 32'h0, "post_rst_press");

        // Randomized pins and bus traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                idx = int'($urandom_range(0, N - 1));
                din[idx] = ~din[idx];
            end
            if ($urandom_range(0, 3) == 0)
                set_bus(1'($urandom_range(0, 1)), 1'b1, 5'($urandom_range(0, 7)), $urandom());
            else begin
                cs = 1'($urandom_range(0, 1));
                wr = 1'b0;
                addr = 5'($urandom_range(0, 7));
            end
            rd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 699) == 0) begin
                rst = 1'b0;
                model_reset();
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce_core.md
Name: btn_debounce_core

Overview:
- MMIO slot core for the push buttons; replaces the plain GPI on the button slot.
- Sits between the raw `btn` pins and the MMIO controller's per-slot bus.
- Synchronises each button, debounces it with a per-bit state machine, and latches press/release edges in sticky registers that software clears.
- Slot-bus timing matches the other slot cores: combinational read mux, writes registered on `clk`.

Parameters:
N_BTN, 3, number of buttons (1..32)
DB_CYCLES, 2_000_000, stable-input cycles required before a level change is accepted (20 ms at 100 MHz); must be >= 2
CNT_W, $clog2(DB_CYCLES), debounce counter width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
cs  in  1  slot chip select
read  in  1  slot read strobe
write  in  1  slot write strobe
addr  in  5  slot register address
wr_data  in  32  write data
rd_data  out  32  read data
din  in  N_BTN  raw button pins, active-high, asynchronous to clk
irq  out  1  level interrupt (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): synchroniser flops, counters, levels, press/release regs, mask all 0; FSMs in S_LOW; irq=0. rd_data is combinational and is therefore 0 for every address after reset.
- Synchroniser: 2-FF per bit, producing sync[i].
- Per-bit FSM states:
  - S_LOW: if sync=1, go to S_WAIT_H with cnt=0.
  - S_WAIT_H: if sync=0, return to S_LOW; else cnt++. When cnt==DB_CYCLES-1 with sync=1, go to S_HIGH, set level=1, pulse rise for 1 cycle.
  - S_HIGH: if sync=0, go to S_WAIT_L with cnt=0.
  - S_WAIT_L: symmetric to S_WAIT_H; ends with level=0 and a 1-cycle fall pulse.
- Latency: a pin change at edge k held stable updates level at edge k+2+DB_CYCLES.
- A glitch shorter than DB_CYCLES never changes level. The counter restarts from 0 on every bounce; no wrap is possible.
- press[i] sets on rise[i]; release[i] sets on fall[i]. Both are sticky.
- Register map (word addr; reads have no side effects):
  - 0: R, {0, level}
  - 1: R/W1C, {0, press}
  - 2: R/W1C, {0, release}
  - 3: R, {0, sync} (raw synchronised pins)
  - 4: R/W, irq mask (macro only; reads 0 otherwise)
  - All other addresses: read 0, writes ignored.
- W1C: cs&write&addr==1 clears press bits where wr_data[i]=1, applied at the next edge. Same for release at addr 2.
- Simultaneous W1C and new edge on the same bit in the same cycle: the set wins; the bit stays 1.
- Bits above N_BTN-1 read 0. wr_data bits above N_BTN-1 are ignored.
- write without cs, or read strobe alone, changes no state.
- Reset asserted mid-debounce: immediate return to S_LOW with cnt=0; no edge is recorded.

Optional Feature:
BTN_DEBOUNCE_IRQ_EN
- Defined:
  - Adds a mask register at addr 4, width N_BTN, reset 0, read/write.
  - irq = |(press & mask), registered, asserted the cycle after press sets.
  - irq deasserts the cycle after W1C clears the last masked press bit, or after mask is cleared.
- Undefined: no mask flops; addr 4 reads 0; irq tied to 0.

Decomposition:
- Package btn_debounce_pkg:
  - Address constants: REG_LEVEL=0, REG_PRESS=1, REG_RELEASE=2, REG_RAW=3, REG_MASK=4.
  - typedef enum logic[1:0] db_state_t {S_LOW, S_WAIT_H, S_HIGH, S_WAIT_L}.
- Sub-module btn_debounce_fsm: one bit, holding the synchroniser, counter and FSM.
  - Outputs: level, rise, fall, sync.
  - Instantiated N_BTN times in a generate loop.
  - Top holds the edge registers, mask, read mux and irq.

Test Plan:
(All with DB_CYCLES=8, N_BTN=3.)
- Reset then read addrs 0,1,2,3,4,7: all return 0x00000000; irq=0.
- din[0] 0->1 at edge k and held: addr0 reads 0x1 from edge k+10, not before; addr1 reads 0x1; addr2 reads 0x0.
- din[1] bounces 1,0,1,0 with 3-cycle pulses, then holds 1: no level change until 8 stable cycles after the final rise; exactly one press bit set (addr1=0x2).
- Release din[0]: addr2=0x1. Write 0x1 to addr2: reads 0x0 next cycle. Write 0x1 to addr1 in the same cycle that rise[2] fires, with press=0x1 beforehand: the result is press=0x4, not 0x5. This covers both ordinary W1C and the set-vs-clear collision.
- Deassert rst while S_WAIT_H is at cnt=5: level stays 0, press stays 0, and the FSM restarts from S_LOW after reset is released.
- With BTN_DEBOUNCE_IRQ_EN: write mask=0x2, press btn[0]: irq stays 0. Press btn[1]: irq=1 one cycle after press sets. W1C 0x2 to addr1: irq=0 the next cycle.
